exu_muldiv_way0: RTL and testbench
==================================

Name: exu_muldiv_way0

Overview:
- Execute-stage consumer of the way0 decode/execute pipeline register. It is the responder side of that register's valid/ready handshake.
- Accepts RV64M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms) and runs them iteratively.
- Back-pressures the decode register through ready_o while busy.
- Presents the rd write-back beat downstream with its own valid/ready pair.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset, sampled on posedge clk
- valid_i  in  1  decode register output beat valid
- ready_o  out  1  block can accept a beat this cycle (combinational)
- rdAddr_i  in  5  destination register
- rdWriteEnable_i  in  1  rd write enable
- instAddr_i  in  32  instruction PC
- rs1ReadData_i  in  64  operand 1
- rs2ReadData_i  in  64  operand 2
- opCode_i  in  7  opcode
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7
- way0_pID_i  in  2  pipeline tag
- flush_i  in  1  kill in-flight operation
- valid_o  out  1  result beat valid
- ready_i  in  1  downstream accepts result
- rdAddr_o  out  5  destination register
- rdWriteEnable_o  out  1  rd write enable
- rdWriteData_o  out  64  result
- instAddr_o  out  32  PC of result
- way0_pID_o  out  2  tag of result
- busy_o  out  1  state != IDLE

Behaviour:
- M-op decode:
  - funct7_i==0000001 and opCode_i==0110011 (64-bit) or 0111011 (W).
  - A valid_i beat that is not an M-op is consumed with no effect (no result produced).
- FSM states: IDLE, MUL, DIV, DONE. Reset and flush_i both force IDLE on the next edge.
- ready_o = (state==IDLE) || (state==DONE && ready_i). ready_o is 0 whenever flush_i=1.
- Accept edge E0 (valid_i && ready_o && M-op):
  - Latch operands, rdAddr, rdWriteEnable, instAddr, pID.
  - Load counter: N=64, or N=32 for W forms.
  - Go to MUL for funct3[2]=0, else DIV.
- MUL: shift-add, one multiplier bit per cycle.
  - Signed forms use operand magnitudes; the 128-bit product is negated when the signs differ.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL returns the low 64 bits; MULH/MULHSU/MULHU return the high 64 bits.
  - MULW: low 32 bits of the product of rs1[31:0]*rs2[31:0], sign-extended.
- DIV: restoring, one quotient bit per cycle, operating on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder takes the sign of the dividend.
  - W forms use bits [31:0] (signed forms sign-extend them); the 32-bit result is always sign-extended to 64.
- Special cases, decided at E0, go straight to DONE (latency 1 edge):
  - Divide by zero: quotient = all ones (XLEN or 32-bit width per form), remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Latency: edges E1..EN each perform one iteration. At EN the state becomes DONE and the result/side-band outputs are registered. Nominal latency is N edges after E0.
- DONE:
  - valid_o=1; all outputs held stable until valid_o && ready_i.
  - On handshake, go to IDLE, or to MUL/DIV if a new beat is accepted the same cycle (back-to-back).
- valid_o is registered and high only in DONE.
- Output reset values: valid_o 0; rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o, way0_pID_o all 0; busy_o 0. ready_o=1 in the first cycle after reset.
- flush_i overrides everything:
  - Any state goes to IDLE; valid_o goes to 0 on the next edge.
  - A DONE result not yet handshaken is dropped.
- Reset mid-operation: same effect as flush, plus all registered outputs clear to 0.
- Side-band outputs (rdAddr_o, etc.) change only on an accept edge or on reset.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in MUL, the state goes to DONE on the edge at which the remaining shifted multiplier bits become zero. Minimum one iteration, so MUL by 0 or 1 completes in 1 edge. DIV is unaffected.
- Undefined: MUL always runs the full N iterations.

Test Plan:
- MUL rs1=7, rs2=6 after reset, ready_i=1 -> ready_o=0 for 64 cycles; valid_o=1 exactly 64 edges after E0 with rdWriteData_o=42, rdAddr_o/pID_o matching the inputs. With MULDIV_EARLY_OUT_EN: latency 3 edges.
- MULH rs1=0xFFFF_FFFF_FFFF_FFFF (-1), rs2=2 -> rdWriteData_o=0xFFFF_FFFF_FFFF_FFFF. MULHU with the same operands -> 1.
- DIV rs1=-7, rs2=2 -> -3; REM with the same operands -> -1. DIVW rs1=0x0000_0000_8000_0000, rs2=-1 (overflow) -> 0xFFFF_FFFF_8000_0000 after 1 edge.
- DIVU rs1=5, rs2=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU with the same operands -> 5; both after 1 edge.
- Hold ready_i=0 for 10 cycles in DONE -> valid_o and data stay stable, ready_o=0. Then ready_i=1 with valid_i=1 -> result handshake and new accept on the same edge.
- Assert flush_i in MUL iteration 20 -> IDLE next edge, valid_o never asserts. Repeat with reset_n=0 mid-DIV -> all outputs 0 next edge.

Source files
------------

// File: rtl/exu_muldiv_way0_if.sv
// Way0 execute-stage M-extension bus: decode beat in, write-back beat out, plus flush/busy.
interface exu_muldiv_way0_if #(
   parameter int XLEN = 64
);
   logic            valid_i;
   logic            ready_o;
   logic [4:0]      rdAddr_i;
   logic            rdWriteEnable_i;
   logic [31:0]     instAddr_i;
   logic [XLEN-1:0] rs1ReadData_i;
   logic [XLEN-1:0] rs2ReadData_i;
   logic [6:0]      opCode_i;
   logic [2:0]      funct3_i;
   logic [6:0]      funct7_i;
   logic [1:0]      way0_pID_i;
   logic            flush_i;
   logic            valid_o;
   logic            ready_i;
   logic [4:0]      rdAddr_o;
   logic            rdWriteEnable_o;
   logic [XLEN-1:0] rdWriteData_o;
   logic [31:0]     instAddr_o;
   logic [1:0]      way0_pID_o;
   logic            busy_o;

   modport master (
      output valid_i, rdAddr_i, rdWriteEnable_i, instAddr_i, rs1ReadData_i, rs2ReadData_i,
             opCode_i, funct3_i, funct7_i, way0_pID_i, flush_i, ready_i,
      input  ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o,
             way0_pID_o, busy_o
   );

   modport slave (
      input  valid_i, rdAddr_i, rdWriteEnable_i, instAddr_i, rs1ReadData_i, rs2ReadData_i,
             opCode_i, funct3_i, funct7_i, way0_pID_i, flush_i, ready_i,
      output ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rdWriteData_o, instAddr_o,
             way0_pID_o, busy_o
   );
endinterface

// File: rtl/exu_muldiv_way0.sv
// Iterative RV64M multiply/divide unit for way0 (shift-add MUL, restoring DIV).
// Optional macro MULDIV_EARLY_OUT_EN: MUL finishes once the remaining multiplier bits are zero.
module exu_muldiv_way0 #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input logic              clk,
   input logic              reset_n,
   exu_muldiv_way0_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

   state_e state_q, state_d;

   logic [4:0]        rdAddr_q;
   logic              rdWe_q;
   logic [31:0]       pc_q;
   logic [1:0]        pid_q;
   logic [XLEN-1:0]   wdata_q;

   logic [2*XLEN-1:0] acc_q, mcand_q;
   logic [XLEN-1:0]   mplier_q, rem_q, quo_q, divisor_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              neg_q, neg_r_q, w_q;
   logic [1:0]        f3_q;

   logic                   is_mop, is_w, accept, a_sgn, b_sgn, neg_a, neg_b;
   logic                   div_zero, div_ovf, special;
   logic [2:0]             f3;
   logic signed [XLEN-1:0] op_a, op_b;
   logic [XLEN-1:0]        mag_a, mag_b, min_val, spec_raw, spec_res;

   assign f3     = bus.funct3_i;
   assign is_w   = (bus.opCode_i == 7'b0111011);
   assign is_mop = (bus.funct7_i == 7'b0000001) && ((bus.opCode_i == 7'b0110011) || is_w);

   assign bus.ready_o = !bus.flush_i && ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.ready_i));
   assign accept      = bus.valid_i && bus.ready_o && is_mop;

   // MUL itself is computed unsigned: its low half does not depend on operand signs
   assign a_sgn = f3[2] ? !f3[0] : ((f3[1:0] == 2'b01) || (f3[1:0] == 2'b10));
   assign b_sgn = f3[2] ? !f3[0] : (f3[1:0] == 2'b01);

   always_comb begin
      op_a = bus.rs1ReadData_i;
      op_b = bus.rs2ReadData_i;
      if (is_w) begin
         op_a = a_sgn ? sext_w(bus.rs1ReadData_i[31:0]) : {{(XLEN-32){1'b0}}, bus.rs1ReadData_i[31:0]};
         op_b = b_sgn ? sext_w(bus.rs2ReadData_i[31:0]) : {{(XLEN-32){1'b0}}, bus.rs2ReadData_i[31:0]};
      end
   end

   assign neg_a   = a_sgn && (op_a < 0);
   assign neg_b   = b_sgn && (op_b < 0);
   assign mag_a   = cond_neg(neg_a, op_a);
   assign mag_b   = cond_neg(neg_b, op_b);
   assign min_val = is_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

   assign div_zero = f3[2] && (op_b == '0);
   assign div_ovf  = f3[2] && !f3[0] && (op_a == min_val) && (&op_b);
   assign special  = div_zero || div_ovf;

   always_comb begin
      if (div_zero) spec_raw = f3[1] ? op_a : '1;
      else          spec_raw = f3[1] ? '0 : min_val;
      spec_res = is_w ? sext_w(spec_raw[31:0]) : spec_raw;
   end

   logic [2*XLEN-1:0] acc_nx, prod;
   logic [XLEN-1:0]   mplier_nx, rem_nx, quo_nx, quo_s, rem_s, div_sel, mul_res, div_res;
   logic [XLEN:0]     partial, diff;
   logic              q_bit, last_iter, mul_last;

   assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mplier_nx = mplier_q >> 1;
   assign partial   = {rem_q, quo_q[XLEN-1]};
   assign diff      = partial - {1'b0, divisor_q};
   assign q_bit     = !diff[XLEN];
   assign rem_nx    = q_bit ? diff[XLEN-1:0] : partial[XLEN-1:0];
   assign quo_nx    = {quo_q[XLEN-2:0], q_bit};
   assign last_iter = (cnt_q == CNT_W'(1));

`ifdef MULDIV_EARLY_OUT_EN
   assign mul_last = last_iter || (mplier_nx == '0);
`else
   assign mul_last = last_iter;
`endif

   assign prod    = neg_q ? -acc_nx : acc_nx;
   assign mul_res = w_q ? sext_w(prod[31:0]) :
                    ((f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
   assign quo_s   = cond_neg(neg_q, quo_nx);
   assign rem_s   = cond_neg(neg_r_q, rem_nx);
   assign div_sel = f3_q[1] ? rem_s : quo_s;
   assign div_res = w_q ? sext_w(div_sel[31:0]) : div_sel;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if ((state_q == S_DONE) && bus.ready_i) state_d = S_IDLE;
            if (accept) state_d = special ? S_DONE : (f3[2] ? S_DIV : S_MUL);
         end
         S_MUL:   if (mul_last)  state_d = S_DONE;
         S_DIV:   if (last_iter) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (bus.flush_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         rdAddr_q <= '0;
         rdWe_q   <= 1'b0;
         pc_q     <= '0;
         pid_q    <= '0;
         wdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rdAddr_q <= bus.rdAddr_i;
            rdWe_q   <= bus.rdWriteEnable_i;
            pc_q     <= bus.instAddr_i;
            pid_q    <= bus.way0_pID_i;
         end
         if (accept && special)
            wdata_q <= spec_res;
         else if ((state_q == S_MUL) && mul_last && !bus.flush_i)
            wdata_q <= mul_res;
         else if ((state_q == S_DIV) && last_iter && !bus.flush_i)
            wdata_q <= div_res;
      end
   end

   // Iteration datapath: W-form dividends are left-aligned so 32 shifts leave the quotient in [31:0]
   always_ff @(posedge clk) begin
      if (accept) begin
         acc_q     <= '0;
         mcand_q   <= {{XLEN{1'b0}}, mag_a};
         mplier_q  <= mag_b;
         rem_q     <= '0;
         quo_q     <= is_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
         divisor_q <= mag_b;
         cnt_q     <= is_w ? CNT_W'(32) : CNT_W'(XLEN);
         neg_q     <= neg_a ^ neg_b;
         neg_r_q   <= neg_a;
         w_q       <= is_w;
         f3_q      <= f3[1:0];
      end else if (state_q == S_MUL) begin
         acc_q    <= acc_nx;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_nx;
         cnt_q    <= cnt_q - CNT_W'(1);
      end else if (state_q == S_DIV) begin
         rem_q <= rem_nx;
         quo_q <= quo_nx;
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign bus.valid_o         = (state_q == S_DONE);
   assign bus.busy_o          = (state_q != S_IDLE);
   assign bus.rdAddr_o        = rdAddr_q;
   assign bus.rdWriteEnable_o = rdWe_q;
   assign bus.instAddr_o      = pc_q;
   assign bus.way0_pID_o      = pid_q;
   assign bus.rdWriteData_o   = wdata_q;

endmodule

// File: tb/tb_exu_muldiv_way0.sv
// Bench for exu_muldiv_way0: directed vector table, handshake/flush/reset sequences, random ops vs model.
module tb_exu_muldiv_way0;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_W = 7'b0111011;
   localparam logic [6:0] F7_M = 7'b0000001;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   logic clk, reset_n;
   int   checks = 0;
   int   errors = 0;

   exu_muldiv_way0_if #(.XLEN(64)) bus ();
   exu_muldiv_way0 #(.XLEN(64), .CNT_W(7)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   // done_edge: index k of the edge Ek (E0 = accept edge) after which valid_o is first seen
   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [63:0] a, b, exp;
      int          edge_full, edge_eo;
   } vec_t;
   vec_t vecs[$];

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [63:0] model_res(input logic [2:0] f3, input bit w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] pa, pb, p;
      logic [63:0] x, y, q, r, res;
      bit sgn;
      if (!f3[2]) begin
         pa = (f3 == 3'd1 || f3 == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
         pb = (f3 == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
         p  = pa * pb;
         if (w) return sext32(p[31:0]);
         return (f3 == 3'd0) ? p[63:0] : p[127:64];
      end
      sgn = !f3[0];
      x = w ? (sgn ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
      y = w ? (sgn ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
      if (y == 64'd0) begin
         q = '1; r = x;
      end else if (sgn && !w && x == 64'h8000_0000_0000_0000 && y == '1) begin
         q = x; r = 64'd0;
      end else if (sgn) begin
         q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
      end else begin
         q = x / y; r = x % y;
      end
      res = f3[1] ? r : q;
      return w ? sext32(res[31:0]) : res;
   endfunction

   function automatic int model_edge(input logic [2:0] f3, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
      logic [63:0] x, y, m;
      int n;
      if (f3[2]) begin
         x = w ? (!f3[0] ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
         y = w ? (!f3[0] ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
         if (y == 64'd0) return 0;
         if (!f3[0] && y == '1 && x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 0;
         return w ? 32 : 64;
      end
      if (!EO) return w ? 32 : 64;
      m = w ? {32'd0, b[31:0]} : ((f3 == 3'd1 && b[63]) ? -b : b);
      n = 0;
      while (m != 64'd0) begin m = m >> 1; n++; end
      return (n < 1) ? 1 : n;
   endfunction

   function automatic logic [63:0] rand64();
      logic [31:0] t;
      t = $urandom;
      case ($urandom_range(0, 6))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'($urandom_range(0, 20));
         4:       return -64'($urandom_range(1, 20));
         5:       return sext32(t);
         default: return {t, 32'($urandom)};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic set_beat(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                           input logic we, input logic [1:0] pid, input logic [31:0] pc);
      bus.opCode_i = opc; bus.funct7_i = f7; bus.funct3_i = f3;
      bus.rs1ReadData_i = a; bus.rs2ReadData_i = b;
      bus.rdAddr_i = rd; bus.rdWriteEnable_i = we; bus.way0_pID_i = pid; bus.instAddr_i = pc;
      bus.valid_i = 1'b1;
   endtask

   task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic we, input logic [1:0] pid, input logic [31:0] pc);
      @(negedge clk);
      set_beat(opc, f7, f3, a, b, rd, we, pid, pc);
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
   endtask

   // Called just after E0; returns once valid_o is seen or the budget runs out.
   task automatic wait_done(input string nm, input int exp_edge);
      int k;
      k = 0;
      chk({nm, " busy"}, 64'(bus.busy_o), 64'd1);
      if (!bus.valid_o) chk({nm, " ready_o while busy"}, 64'(bus.ready_o), 64'd0);
      while (!bus.valid_o && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, " done edge"}, 64'(k), 64'(exp_edge));
   endtask

   task automatic check_out(input string nm, input logic [63:0] exp, input logic [4:0] rd,
                            input logic we, input logic [1:0] pid, input logic [31:0] pc);
      chk({nm, " data"}, bus.rdWriteData_o, exp);
      chk({nm, " rd"}, 64'(bus.rdAddr_o), 64'(rd));
      chk({nm, " we"}, 64'(bus.rdWriteEnable_o), 64'(we));
      chk({nm, " pid"}, 64'(bus.way0_pID_o), 64'(pid));
      chk({nm, " pc"}, 64'(bus.instAddr_o), 64'(pc));
   endtask

   task automatic handshake(input string nm);
      @(posedge clk); #1;
      chk({nm, " valid after handshake"}, 64'(bus.valid_o), 64'd0);
   endtask

   task automatic expect_no_valid(input string nm, input int cycles);
      bit seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (bus.valid_o) seen = 1'b1;
      end
      chk({nm, " valid never"}, 64'(seen), 64'd0);
   endtask

   task automatic check_cleared(input string nm);
      chk({nm, " valid"}, 64'(bus.valid_o), 64'd0);
      chk({nm, " busy"}, 64'(bus.busy_o), 64'd0);
      check_out(nm, 64'd0, 5'd0, 1'b0, 2'd0, 32'd0);
   endtask

   initial begin
      logic [63:0] a, b, e;
      logic [2:0]  f3;
      logic [4:0]  rd, last_rd;
      logic [1:0]  pid;
      logic [31:0] pc;
      logic        we;
      bit          w, is_div;
      int          hold;

      vecs.push_back('{OP_R, 3'd0, 64'd7, 64'd6, 64'd42, 64, 3});
      vecs.push_back('{OP_R, 3'd1, '1, 64'd2, '1, 64, 2});
      vecs.push_back('{OP_R, 3'd3, '1, 64'd2, 64'd1, 64, 2});
      vecs.push_back('{OP_R, 3'd2, '1, 64'd2, '1, 64, 2});
      vecs.push_back('{OP_W, 3'd0, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 2});
      vecs.push_back('{OP_R, 3'd4, -64'd7, 64'd2, -64'd3, 64, 64});
      vecs.push_back('{OP_R, 3'd6, -64'd7, 64'd2, '1, 64, 64});
      vecs.push_back('{OP_R, 3'd5, 64'd100, 64'd7, 64'd14, 64, 64});
      vecs.push_back('{OP_W, 3'd7, 64'hFFFF_FFFF_0000_0011, 64'd5, 64'd2, 32, 32});
      vecs.push_back('{OP_W, 3'd6, -64'd7, 64'd2, '1, 32, 32});
      vecs.push_back('{OP_W, 3'd4, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, 0});
      vecs.push_back('{OP_R, 3'd5, 64'd5, 64'd0, '1, 0, 0});
      vecs.push_back('{OP_R, 3'd7, 64'd5, 64'd0, 64'd5, 0, 0});
      vecs.push_back('{OP_R, 3'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 0});
      vecs.push_back('{OP_R, 3'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 0, 0});
      vecs.push_back('{OP_W, 3'd6, 64'h1_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 0, 0});
      vecs.push_back('{OP_W, 3'd5, 64'd7, 64'd0, '1, 0, 0});

      reset_n = 1'b0;
      bus.flush_i = 1'b0; bus.ready_i = 1'b1;
      set_beat(OP_R, 7'd0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0, 2'd0, 32'd0);
      bus.valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_cleared("reset");
      @(negedge clk);
      reset_n = 1'b1;
      chk("ready after reset", 64'(bus.ready_o), 64'd1);

      // Directed vectors
      foreach (vecs[i]) begin
         rd = 5'(i + 1); pid = 2'(i); pc = 32'h1000 + 32'(i * 4); we = i[0];
         issue(vecs[i].opc, F7_M, vecs[i].f3, vecs[i].a, vecs[i].b, rd, we, pid, pc);
         wait_done($sformatf("vec%0d", i), EO ? vecs[i].edge_eo : vecs[i].edge_full);
         check_out($sformatf("vec%0d", i), vecs[i].exp, rd, we, pid, pc);
         handshake($sformatf("vec%0d", i));
      end

      // Back-pressure in DONE, then handshake and new accept on the same edge
      bus.ready_i = 1'b0;
      issue(OP_R, F7_M, 3'd5, 64'd5, 64'd0, 5'd3, 1'b1, 2'd1, 32'h2000);
      wait_done("hold", 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d valid", i), 64'(bus.valid_o), 64'd1);
         chk($sformatf("hold%0d data", i), bus.rdWriteData_o, '1);
         chk($sformatf("hold%0d ready_o", i), 64'(bus.ready_o), 64'd0);
      end
      check_out("hold", '1, 5'd3, 1'b1, 2'd1, 32'h2000);
      @(negedge clk);
      bus.ready_i = 1'b1;
      set_beat(OP_R, F7_M, 3'd0, 64'd3, 64'd5, 5'd17, 1'b1, 2'd2, 32'h2004);
      #1 chk("b2b ready_o in DONE", 64'(bus.ready_o), 64'd1);
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      chk("b2b valid dropped", 64'(bus.valid_o), 64'd0);
      chk("b2b rd latched", 64'(bus.rdAddr_o), 64'd17);
      wait_done("b2b", model_edge(3'd0, 1'b0, 64'd3, 64'd5));
      check_out("b2b", 64'd15, 5'd17, 1'b1, 2'd2, 32'h2004);
      handshake("b2b");

      // Flush during MUL iteration 20
      issue(OP_R, F7_M, 3'd3, 64'd3, 64'h8000_0000_0000_0001, 5'd5, 1'b1, 2'd3, 32'h3000);
      repeat (19) @(posedge clk);
      @(negedge clk);
      bus.flush_i = 1'b1;
      #1 chk("flush ready_o", 64'(bus.ready_o), 64'd0);
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      chk("flush busy", 64'(bus.busy_o), 64'd0);
      chk("flush valid", 64'(bus.valid_o), 64'd0);
      expect_no_valid("flush", 80);

      // Reset during DIV
      issue(OP_R, F7_M, 3'd4, -64'd100, 64'd7, 5'd9, 1'b1, 2'd3, 32'h4000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_cleared("mid-div reset");
      @(negedge clk);
      reset_n = 1'b1;
      expect_no_valid("mid-div reset", 80);

      // Randomized operations against the reference model
      last_rd = 5'd0;
      for (int i = 0; i < 40; i++) begin
         is_div = 1'($urandom_range(0, 1));
         w      = 1'($urandom_range(0, 1));
         f3     = is_div ? 3'($urandom_range(4, 7)) : (w ? 3'd0 : 3'($urandom_range(0, 3)));
         a = rand64(); b = rand64();
         rd = 5'($urandom_range(1, 31)); pid = 2'($urandom); pc = $urandom; we = 1'($urandom);
         e = model_res(f3, w, a, b);
         hold = $urandom_range(0, 3);
         bus.ready_i = (hold == 0);
         issue(w ? OP_W : OP_R, F7_M, f3, a, b, rd, we, pid, pc);
         wait_done($sformatf("rnd%0d f3=%0d w=%0d", i, f3, w), model_edge(f3, w, a, b));
         check_out($sformatf("rnd%0d f3=%0d w=%0d a=%h b=%h", i, f3, w, a, b), e, rd, we, pid, pc);
         last_rd = rd;
         for (int j = 0; j < hold; j++) begin
            @(posedge clk); #1;
            chk($sformatf("rnd%0d held valid", i), 64'(bus.valid_o), 64'd1);
            chk($sformatf("rnd%0d held data", i), bus.rdWriteData_o, e);
         end
         @(negedge clk);
         bus.ready_i = 1'b1;
         handshake($sformatf("rnd%0d", i));
         if ($urandom_range(0, 2) == 0) begin
            if (i[0]) issue(OP_R, 7'd0, f3, a, b, 5'd0, 1'b1, 2'd0, 32'hDEAD);
            else      issue(7'b0010011, F7_M, f3, a, b, 5'd0, 1'b1, 2'd0, 32'hDEAD);
            chk($sformatf("rnd%0d non-M busy", i), 64'(bus.busy_o), 64'd0);
            chk($sformatf("rnd%0d non-M valid", i), 64'(bus.valid_o), 64'd0);
            chk($sformatf("rnd%0d non-M rd kept", i), 64'(bus.rdAddr_o), 64'(last_rd));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
